// File: rtl/decode_feed_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decode_feed_sequencer                                                      |
// | Buffers fetched instruction/address pairs and issues one per cycle to the  |
// | format decoder; honours downstream stall and pipeline flush.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module decode_feed_sequencer #(
  parameter int instructionWidth = 32,
  parameter int addressSize      = 64,
  parameter int depth            = 4,
  parameter int ptrWidth         = 2
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        flush_i,
  input  logic                        fetchValid_i,
  input  logic [0:instructionWidth-1] instruction_i,
  input  logic [0:addressSize-1]      address_i,
  output logic                        fetchReady_o,
  input  logic                        stall_i,
  output logic                        decodeEnable_o,
  output logic [0:instructionWidth-1] instruction_o,
  output logic [0:addressSize-1]      address_o,
  output logic [ptrWidth:0]           occupancy_o,
  output logic                        empty_o,
  output logic                        full_o
);

  localparam logic [ptrWidth:0]   c_depth   = (ptrWidth + 1)'(depth);
  localparam logic [ptrWidth:0]   c_occ_one = (ptrWidth + 1)'(1);
  localparam logic [ptrWidth-1:0] c_ptr_one = ptrWidth'(1);

  logic [0:instructionWidth-1] r_instr_mem [depth];
  logic [0:addressSize-1]      r_addr_mem  [depth];

  logic [ptrWidth-1:0]         r_wr_ptr;
  logic [ptrWidth-1:0]         r_rd_ptr;
  logic [ptrWidth:0]           r_occupancy;
  logic                        r_decode_enable;
  logic [0:instructionWidth-1] r_instruction;
  logic [0:addressSize-1]      r_address;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  // Readiness comes from the occupancy register alone; a same-cycle pop
  // never frees a slot for the word offered in that cycle.
  assign w_empty = (r_occupancy == '0);
  assign w_full  = (r_occupancy == c_depth);
  assign w_push  = fetchValid_i & ~w_full & ~flush_i;
  assign w_pop   = ~w_empty & ~stall_i & ~flush_i;

  assign fetchReady_o   = ~w_full;
  assign empty_o        = w_empty;
  assign full_o         = w_full;
  assign occupancy_o    = r_occupancy;
  assign decodeEnable_o = r_decode_enable;
  assign instruction_o  = r_instruction;
  assign address_o      = r_address;

  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= instruction_i;
      r_addr_mem[r_wr_ptr]  <= address_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occupancy <= '0;
    end else if (flush_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occupancy <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_occupancy <= r_occupancy + c_occ_one;
      end else if (!w_push && w_pop) begin
        r_occupancy <= r_occupancy - c_occ_one;
      end
    end
  end

  // Flush only drops the enable; data outputs keep their last issued value.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_decode_enable <= 1'b0;
      r_instruction   <= '0;
      r_address       <= '0;
    end else begin
      r_decode_enable <= w_pop;
      if (w_pop) begin
        r_instruction <= r_instr_mem[r_rd_ptr];
        r_address     <= r_addr_mem[r_rd_ptr];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_feed_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_decode_feed_sequencer                                                   |
// | Directed and random stimulus against a queue-based reference model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_decode_feed_sequencer;

  localparam int DEPTH = 4;

  logic          clock_i;
  logic          reset_i;
  logic          flush_i;
  logic          fetchValid_i;
  logic [0:31]   instruction_i;
  logic [0:63]   address_i;
  logic          fetchReady_o;
  logic          stall_i;
  logic          decodeEnable_o;
  logic [0:31]   instruction_o;
  logic [0:63]   address_o;
  logic [2:0]    occupancy_o;
  logic          empty_o;
  logic          full_o;

  decode_feed_sequencer #(
    .instructionWidth(32),
    .addressSize     (64),
    .depth           (DEPTH),
    .ptrWidth        (2)
  ) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .flush_i       (flush_i),
    .fetchValid_i  (fetchValid_i),
    .instruction_i (instruction_i),
    .address_i     (address_i),
    .fetchReady_o  (fetchReady_o),
    .stall_i       (stall_i),
    .decodeEnable_o(decodeEnable_o),
    .instruction_o (instruction_o),
    .address_o     (address_o),
    .occupancy_o   (occupancy_o),
    .empty_o       (empty_o),
    .full_o        (full_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  typedef struct {
    logic [31:0] ins;
    logic [63:0] a;
  } entry_t;

  entry_t      q[$];
  logic        exp_en;
  logic [31:0] exp_ins;
  logic [63:0] exp_addr;
  int          tests;
  int          failed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, check pre-edge status, advance model, check issue.
  task automatic cycle(input bit v, input logic [31:0] ins, input logic [63:0] a,
                       input bit st, input bit fl, output bit acc);
    bit     pop;
    entry_t e;
    fetchValid_i  = v;
    instruction_i = ins;
    address_i     = a;
    stall_i       = st;
    flush_i       = fl;
    #1;
    chk("ready", 64'(fetchReady_o), 64'(q.size() < DEPTH));
    chk("occupancy", 64'(occupancy_o), 64'(q.size()));
    chk("empty", 64'(empty_o), 64'(q.size() == 0));
    chk("full", 64'(full_o), 64'(q.size() == DEPTH));
    acc = v && (q.size() < DEPTH) && !fl;
    pop = (q.size() > 0) && !st && !fl;
    exp_en = pop;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) begin
        e        = q.pop_front();
        exp_ins  = e.ins;
        exp_addr = e.a;
      end
      if (acc) begin
        e.ins = ins;
        e.a   = a;
        q.push_back(e);
      end
    end
    @(posedge clock_i);
    #1;
    chk("enable", 64'(decodeEnable_o), 64'(exp_en));
    chk("instr", 64'(instruction_o), 64'(exp_ins));
    chk("addr", address_o, exp_addr);
  endtask

  initial begin
    bit          acc;
    int          idx;
    logic [31:0] items [5];
    tests    = 0;
    failed   = 0;
    exp_en   = 1'b0;
    exp_ins  = '0;
    exp_addr = '0;
    reset_i       = 1'b0;
    flush_i       = 1'b0;
    fetchValid_i  = 1'b0;
    stall_i       = 1'b0;
    instruction_i = '0;
    address_i     = '0;

    // Reset state
    #3;
    chk("rst_enable", 64'(decodeEnable_o), 64'd0);
    chk("rst_instr", 64'(instruction_o), 64'd0);
    chk("rst_addr", address_o, 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_ready", 64'(fetchReady_o), 64'd1);
    #9;
    reset_i = 1'b1;

    // Single push, two-cycle latency
    cycle(1'b1, 32'h7C0802A6, 64'h1000, 1'b0, 1'b0, acc);
    chk("single_not_early", 64'(decodeEnable_o), 64'd0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("single_en", 64'(decodeEnable_o), 64'd1);
    chk("single_instr", 64'(instruction_o), 64'h7C0802A6);
    chk("single_addr", address_o, 64'h1000);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("single_drained", 64'(occupancy_o), 64'd0);

    // Back-to-back stream of 8
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, $urandom, 64'h2000 + 64'(4 * i), 1'b0, 1'b0, acc);
      chk("stream_occ_le1", 64'(occupancy_o <= 3'd1), 64'd1);
      chk("stream_ready", 64'(fetchReady_o), 64'd1);
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);

    // Stall fill with fetch holding the 5th word, then release while valid
    for (int i = 0; i < 5; i++) items[i] = $urandom;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, items[idx], 64'h3000 + 64'(idx), 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    chk("stall_accepted4", 64'(idx), 64'd4);
    chk("stall_full", 64'(full_o), 64'd1);
    chk("stall_not_ready", 64'(fetchReady_o), 64'd0);
    cycle(1'b1, items[idx], 64'h3000 + 64'(idx), 1'b0, 1'b0, acc);
    chk("full_pop_rejects_push", 64'(acc), 64'd0);
    cycle(1'b1, items[idx], 64'h3000 + 64'(idx), 1'b0, 1'b0, acc);
    chk("next_cycle_accepts", 64'(acc), 64'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);

    // Pointer wrap: four more stalled pushes then drain
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 64'h4000 + 64'(i), 1'b1, 1'b0, acc);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);

    // Flush at occupancy 3 with a word offered
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 64'h5000 + 64'(i), 1'b1, 1'b0, acc);
    cycle(1'b1, 32'hDEADBEEF, 64'h5FFF, 1'b0, 1'b1, acc);
    chk("flush_occ", 64'(occupancy_o), 64'd0);
    chk("flush_empty", 64'(empty_o), 64'd1);
    chk("flush_no_en", 64'(decodeEnable_o), 64'd0);
    cycle(1'b1, 32'h12345678, 64'h6000, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("post_flush_instr", 64'(instruction_o), 64'h12345678);

    // Asynchronous reset between edges at occupancy 2
    for (int i = 0; i < 2; i++) cycle(1'b1, $urandom, 64'h7000 + 64'(i), 1'b1, 1'b0, acc);
    cycle(1'b1, $urandom, 64'h7100, 1'b0, 1'b0, acc);
    #2;
    reset_i = 1'b0;
    #1;
    q.delete();
    exp_en   = 1'b0;
    exp_ins  = '0;
    exp_addr = '0;
    chk("async_occ", 64'(occupancy_o), 64'd0);
    chk("async_en", 64'(decodeEnable_o), 64'd0);
    chk("async_instr", 64'(instruction_o), 64'd0);
    chk("async_addr", address_o, 64'd0);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_empty", 64'(empty_o), 64'd1);
    chk("async_ready", 64'(fetchReady_o), 64'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom, {$urandom, $urandom},
            $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, acc);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_feed_sequencer.md
Name: decode_feed_sequencer

Overview:
Sequencer in front of the instruction-format decode stage. It buffers fetched instruction words with their addresses in a small FIFO, accepts them from fetch through a valid/ready handshake, and issues them one per cycle to the format decoder as an enable pulse plus instruction and address. It honours a stall from downstream and a pipeline flush.

Parameters:
instructionWidth, 32, instruction word width (bit 0 = MSB, MSB-0 numbering as in the rest of the pipeline)
addressSize, 64, instruction address width
depth, 4, FIFO entries; power of two, minimum 2
ptrWidth, 2, log2(depth)

Ports:
clock_i  input  1  pipeline clock, all state changes on its rising edge
reset_i  input  1  asynchronous, active-low reset
flush_i  input  1  discard all buffered instructions (branch redirect/exception)
fetchValid_i  input  1  fetch presents a valid instruction this cycle
instruction_i  input  [0:instructionWidth-1]  fetched instruction word
address_i  input  [0:addressSize-1]  address of instruction_i
fetchReady_o  output  1  sequencer can accept an instruction this cycle
stall_i  input  1  downstream decode cannot take an instruction this cycle
decodeEnable_o  output  1  registered; high for exactly one cycle per issued instruction
instruction_o  output  [0:instructionWidth-1]  registered issued instruction
address_o  output  [0:addressSize-1]  registered issued address
occupancy_o  output  ptrWidth+1  number of buffered (not yet issued) entries, 0..depth
empty_o  output  1  occupancy_o == 0
full_o  output  1  occupancy_o == depth

Behaviour:
- Reset (reset_i low, asynchronous): write/read pointers 0, occupancy 0, decodeEnable_o 0, instruction_o 0, address_o 0. Then empty_o=1, full_o=0, fetchReady_o=1. Buffer contents are don't-care.
- fetchReady_o = !full_o, combinational from the occupancy register only. It does not depend on a same-cycle pop: a full FIFO rejects a push even when an issue happens in that cycle.
- Push: fetchValid_i & fetchReady_o & !flush_i. Writes the entry at the write pointer, which then increments modulo depth and wraps.
- Issue (pop): !empty_o & !stall_i & !flush_i. On the edge, instruction_o/address_o take the head entry, decodeEnable_o goes 1 and the read pointer increments modulo depth.
- When no issue occurs, decodeEnable_o goes 0 and instruction_o/address_o hold their previous values.
- No bypass. An instruction pushed at edge N is issued at edge N+1 at the earliest, so decodeEnable_o is high in the cycle after edge N+1. Minimum fetch-to-decode latency is 2 cycles.
- Simultaneous push and pop: occupancy is unchanged. When occupancy is 1 the old head issues and the new entry becomes the head.
- Throughput: one instruction per cycle in steady state with fetchValid_i=1 and stall_i=0.
- Stall: while stall_i=1, nothing issues, decodeEnable_o=0 and the outputs hold. Pushes continue until the FIFO is full.
- Flush has priority over push and issue in the same cycle. On the edge, pointers and occupancy go to 0 and decodeEnable_o goes 0. instruction_o/address_o hold their values; they are meaningless while enable is 0. The fetch word offered in the flush cycle is dropped.
- Order: strictly FIFO. Every accepted instruction is issued exactly once unless a flush discards it.
- Reset asserted mid-operation: the same effect as a flush, applied asynchronously, and it also clears the data outputs.

Test Plan:
- Reset then a single push of instr 0x7C0802A6, addr 0x1000 with stall_i=0 -> decodeEnable_o high for 1 cycle, 2 cycles after the push edge, with those exact values; occupancy returns to 0.
- Stream 8 instructions back-to-back with stall_i=0 -> 8 consecutive enable pulses in order; occupancy never exceeds 1; fetchReady_o stays 1.
- Hold stall_i=1 and push 5 -> first 4 accepted, full_o=1, fetchReady_o=0, 5th held by fetch. Release stall -> 4 issues in order. Pointer wrap is checked by a further 4 pushes and issues.
- Full FIFO with stall_i dropping while fetchValid_i=1 -> the issue happens but the push is rejected that cycle; the push is accepted the next cycle; no duplicate or lost entries.
- Occupancy 3, then flush_i together with fetchValid_i and !stall_i -> next cycle occupancy 0, empty_o=1, no enable pulse, the flushed-cycle word never issues; the subsequent push issues normally.
- Assert reset_i low asynchronously between edges with occupancy 2 -> outputs clear immediately; after release, empty_o=1 and fetchReady_o=1.
